multi_chan_buffer: RTL and testbench



---
 rtl/multi_chan_buffer_pkg.sv | 35 +++
 rtl/multi_chan_buffer_rr_arbiter.sv | 21 ++
 rtl/multi_chan_buffer.sv | 137 +++++++++++++
 tb/tb_multi_chan_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_chan_buffer_pkg.sv
// Shared types and the round-robin search helper for the multi-channel buffer.
// Channel counts up to 32 are supported by rr_next.
package multi_chan_buffer_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_HELD  = 1'b1
   } slot_state_e;

   // First set bit of req searching from last+1 upward, wrapping at n; returns last when req is empty.
   function automatic int unsigned rr_next(
      input logic [31:0] req,
      input int unsigned last,
      input int unsigned n
   );
      int unsigned idx;
      int unsigned gnt;
      logic        found;
      idx   = last;
      gnt   = last;
      found = 1'b0;
      for (int unsigned k = 0; k < 32; k++) begin
         if (k < n) begin
            idx = idx + 1;
            if (idx >= n) idx = 0;
            if (!found && req[idx[4:0]]) begin
               gnt   = idx;
               found = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/multi_chan_buffer_rr_arbiter.sv
// Combinational round-robin arbiter; the last-grant register lives in the parent.
module rr_arbiter
   import multi_chan_buffer_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   input  logic         en,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_valid
);

   logic [31:0] req_ext;

   assign req_ext   = 32'(req);
   assign gnt_idx   = W'(rr_next(req_ext, 32'(last), N));
   assign gnt_valid = en && (|req);

endmodule

// File: rtl/multi_chan_buffer.sv
// Multi-channel FIFO buffer: tagged writes into per-channel queues, drained round-robin
// into one registered output slot.
//
//   state      | meaning
//   SLOT_EMPTY | output register holds nothing, o_valid low
//   SLOT_HELD  | output register holds a word awaiting i_ready
module multi_chan_buffer
   import multi_chan_buffer_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int N_CHAN = 4,
   parameter  int DEPTH  = 4,
   localparam int CH_W   = $clog2(N_CHAN),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CH_W-1:0]   i_chan,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [N_CHAN-1:0] i_flush,
   output logic [DATA_W-1:0] o_data,
   output logic [CH_W-1:0]   o_chan,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [CNT_W-1:0]  o_level [N_CHAN],
   output logic [N_CHAN-1:0] o_empty,
   output logic [N_CHAN-1:0] o_full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [N_CHAN][DEPTH];
   logic [PTR_W-1:0]  wr_ptr_a [N_CHAN];
   logic [PTR_W-1:0]  rd_ptr_a [N_CHAN];

   slot_state_e       slot_state;
   slot_state_e       slot_next;
   logic [CH_W-1:0]   last_grant;
   logic [N_CHAN-1:0] req;
   logic [CH_W-1:0]   gnt_idx;
   logic              gnt_valid;
   logic              slot_free;
   logic              pop;
   logic              wr_ok;

   // Channel indices beyond N_CHAN (non power-of-two counts) are never ready.
   always_comb begin
      o_ready = 1'b0;
      for (int c = 0; c < N_CHAN; c++) begin
         if (i_chan == CH_W'(c)) o_ready = !o_full[c];
      end
   end

   assign wr_ok     = i_valid && o_ready;
   assign o_valid   = (slot_state == SLOT_HELD);
   assign slot_free = !o_valid || i_ready;
   // A flushed channel must not win the arbiter in its flush cycle.
   assign req       = ~o_empty & ~i_flush;

   rr_arbiter #(.N(N_CHAN)) u_arb (
      .req       (req),
      .last      (last_grant),
      .en        (slot_free),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
      logic [PTR_W-1:0] wr_ptr;
      logic [PTR_W-1:0] rd_ptr;
      logic [CNT_W-1:0] level;
      logic             wr_en;
      logic             rd_en;

      assign wr_en = wr_ok && (i_chan == CH_W'(c));
      assign rd_en = pop && (gnt_idx == CH_W'(c));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else if (i_flush[c]) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (wr_en && !rd_en)      level <= level + 1'b1;
            else if (rd_en && !wr_en) level <= level - 1'b1;
         end
      end

      assign wr_ptr_a[c] = wr_ptr;
      assign rd_ptr_a[c] = rd_ptr;
      assign o_level[c]  = level;
      assign o_empty[c]  = (level == '0);
      assign o_full[c]   = (level == CNT_W'(DEPTH));
   end

   always_ff @(posedge i_clk) begin
      if (wr_ok) mem[i_chan][wr_ptr_a[i_chan]] <= i_data;
   end

   always_comb begin
      slot_next = slot_state;
      pop       = 1'b0;
      if (slot_free) begin
         if (gnt_valid) begin
            slot_next = SLOT_HELD;
            pop       = 1'b1;
         end else begin
            slot_next = SLOT_EMPTY;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         slot_state <= SLOT_EMPTY;
         o_data     <= '0;
         o_chan     <= '0;
         last_grant <= CH_W'(N_CHAN - 1);
      end else begin
         slot_state <= slot_next;
         if (pop) begin
            o_data     <= mem[gnt_idx][rd_ptr_a[gnt_idx]];
            o_chan     <= gnt_idx;
            last_grant <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_multi_chan_buffer.sv
// Directed bench for multi_chan_buffer: default instance plus a DEPTH=3 instance for wrap/reset.
module tb_multi_chan_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic [7:0] data;
   logic [1:0] chan;
   logic       valid;
   logic       rdy;
   logic [3:0] flush;
   logic [7:0] odata;
   logic [1:0] ochan;
   logic       ovalid;
   logic       ready_in;
   logic [2:0] level [4];
   logic [3:0] empty;
   logic [3:0] full;

   logic [7:0] data_w;
   logic [1:0] chan_w;
   logic       valid_w;
   logic       rdy_w;
   logic [3:0] flush_w;
   logic [7:0] odata_w;
   logic [1:0] ochan_w;
   logic       ovalid_w;
   logic       ready_w;
   logic [1:0] level_w [4];
   logic [3:0] empty_w;
   logic [3:0] full_w;

   int n_assert = 0;
   int n_fail   = 0;

   multi_chan_buffer #(.DATA_W(8), .N_CHAN(4), .DEPTH(4)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (data),
      .i_chan  (chan),
      .i_valid (valid),
      .o_ready (rdy),
      .i_flush (flush),
      .o_data  (odata),
      .o_chan  (ochan),
      .o_valid (ovalid),
      .i_ready (ready_in),
      .o_level (level),
      .o_empty (empty),
      .o_full  (full)
   );

   multi_chan_buffer #(.DATA_W(8), .N_CHAN(4), .DEPTH(3)) u_wrap (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (data_w),
      .i_chan  (chan_w),
      .i_valid (valid_w),
      .o_ready (rdy_w),
      .i_flush (flush_w),
      .o_data  (odata_w),
      .o_chan  (ochan_w),
      .o_valid (ovalid_w),
      .i_ready (ready_w),
      .o_level (level_w),
      .o_empty (empty_w),
      .o_full  (full_w)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [1:0] wch [6];
   logic [7:0] wd  [6];
   logic [1:0] ech [5];
   logic [7:0] ed  [5];
   int         exp_w;

   initial begin
      rst_n = 1'b1;
      data = '0; chan = '0; valid = 1'b0; flush = '0; ready_in = 1'b0;
      data_w = '0; chan_w = '0; valid_w = 1'b0; flush_w = '0; ready_w = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) tick();

      // reset state
      check("rst_valid", 32'(ovalid), 0);
      check("rst_data", 32'(odata), 0);
      check("rst_chan", 32'(ochan), 0);
      check("rst_empty", 32'(empty), 32'hF);
      check("rst_full", 32'(full), 0);
      for (int k = 0; k < 4; k++) check("rst_level", 32'(level[k]), 0);
      rst_n = 1'b1;
      check("rst_ready", 32'(rdy), 1);

      // single write, latency 2
      data = 8'hA5; chan = 2'd2; valid = 1'b1;
      #1 check("t1_ready", 32'(rdy), 1);
      tick();
      valid = 1'b0;
      check("t1_level_c1", 32'(level[2]), 1);
      check("t1_valid_c1", 32'(ovalid), 0);
      tick();
      check("t1_valid_c2", 32'(ovalid), 1);
      check("t1_data_c2", 32'(odata), 32'hA5);
      check("t1_chan_c2", 32'(ochan), 2);
      check("t1_level_c2", 32'(level[2]), 0);
      ready_in = 1'b1;
      tick();
      check("t1_drained", 32'(ovalid), 0);

      // fill channel 1 behind a held slot
      ready_in = 1'b0;
      data = 8'h50; chan = 2'd0; valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      check("t2_slot_valid", 32'(ovalid), 1);
      check("t2_slot_data", 32'(odata), 32'h50);
      for (int i = 0; i < 4; i++) begin
         data = 8'h11 + 8'(i); chan = 2'd1; valid = 1'b1;
         tick();
         if (i == 2) check("t2_full_at3", 32'(full[1]), 0);
      end
      check("t2_full_at4", 32'(full[1]), 1);
      check("t2_level_at4", 32'(level[1]), 4);
      data = 8'h15; chan = 2'd1;
      #1 check("t2_ready_c1", 32'(rdy), 0);
      chan = 2'd0;
      #1 check("t2_ready_c0", 32'(rdy), 1);
      chan = 2'd1;
      tick();
      valid = 1'b0;
      check("t2_refused_level", 32'(level[1]), 4);

      // slot holds while i_ready is low
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold_valid", 32'(ovalid), 1);
         check("t4_hold_data", 32'(odata), 32'h50);
         check("t4_hold_chan", 32'(ochan), 0);
      end
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_drain_data", 32'(odata), 32'h11 + 32'(i));
         check("t4_drain_chan", 32'(ochan), 1);
         check("t4_drain_valid", 32'(ovalid), 1);
      end
      tick();
      check("t4_idle", 32'(ovalid), 0);

      // round-robin across channels 0,1,3
      ready_in = 1'b0;
      wch = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
      wd  = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hD0, 8'hD1};
      for (int i = 0; i < 6; i++) begin
         data = wd[i]; chan = wch[i]; valid = 1'b1;
         tick();
      end
      valid = 1'b0;
      check("t3_first_valid", 32'(ovalid), 1);
      check("t3_first_data", 32'(odata), 32'hA0);
      check("t3_first_chan", 32'(ochan), 0);
      ech = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      ed  = '{8'hB0, 8'hD0, 8'hA1, 8'hB1, 8'hD1};
      ready_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_rr_valid", 32'(ovalid), 1);
         check("t3_rr_chan", 32'(ochan), 32'(ech[i]));
         check("t3_rr_data", 32'(odata), 32'(ed[i]));
      end
      tick();
      check("t3_idle", 32'(ovalid), 0);

      // flush on the third write to channel 1
      ready_in = 1'b0;
      data = 8'hE0; chan = 2'd1; valid = 1'b1;
      tick();
      data = 8'hE1;
      tick();
      check("t5_slot_data", 32'(odata), 32'hE0);
      data = 8'hE2; flush = 4'b0010;
      tick();
      valid = 1'b0; flush = '0;
      check("t5_level", 32'(level[1]), 0);
      check("t5_empty", 32'(empty[1]), 1);
      check("t5_slot_kept", 32'(ovalid), 1);
      check("t5_slot_kept_data", 32'(odata), 32'hE0);
      ready_in = 1'b1;
      tick();
      check("t5_dropped", 32'(ovalid), 0);
      data = 8'hF0; chan = 2'd1; valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      check("t5_after_valid", 32'(ovalid), 1);
      check("t5_after_data", 32'(odata), 32'hF0);
      tick();
      check("t5_after_idle", 32'(ovalid), 0);

      // DEPTH=3: stream 1..10 through channel 0
      exp_w = 1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc < 10) begin
            data_w = 8'(cyc + 1); chan_w = 2'd0; valid_w = 1'b1;
         end else begin
            valid_w = 1'b0;
         end
         tick();
         if (ovalid_w) begin
            check("t6_order", 32'(odata_w), 32'(exp_w));
            exp_w++;
         end
      end
      check("t6_count", 32'(exp_w), 11);

      // DEPTH=3 fill, then asynchronous reset mid-stream
      ready_w = 1'b0;
      for (int i = 0; i < 4; i++) begin
         data_w = 8'h21 + 8'(i); chan_w = 2'd0; valid_w = 1'b1;
         tick();
      end
      check("t6_full", 32'(full_w[0]), 1);
      check("t6_level", 32'(level_w[0]), 3);
      check("t6_ready", 32'(rdy_w), 0);
      check("t6_slot", 32'(odata_w), 32'h21);
      check("t6_pre_rst_valid", 32'(ovalid_w), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(ovalid_w), 0);
      check("t6_rst_level", 32'(level_w[0]), 0);
      check("t6_rst_empty", 32'(empty_w), 32'hF);
      check("t6_rst_full", 32'(full_w), 0);
      valid_w = 1'b0;
      tick();
      rst_n = 1'b1;
      ready_w = 1'b1;
      data_w = 8'h31; chan_w = 2'd0; valid_w = 1'b1;
      tick();
      valid_w = 1'b0;
      tick();
      check("t6_post_rst_valid", 32'(ovalid_w), 1);
      check("t6_post_rst_data", 32'(odata_w), 32'h31);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
